conv_sched: RTL and testbench

Periodic frame scheduler for the acquisition/transmit chain. Each frame runs three stages in order: ADC conversion (fs_conv/fd_conv), ADC-to-RAM transfer (fs_tran/fd_tran) and COM send (fs_send/fd_send), each over a four-phase fs/fd handshake. It sits beside the top-level console, runs on the 50 MHz system clock, and adds a sample-period timer, overrun counting and per-stage watchdog timeouts.

---
 rtl/conv_sched.sv | 157 +++++++++++++++
 tb/tb_conv_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// Frame scheduler: a period timer starts conv -> tran -> send handshake chains,
// with overrun counting and a per-state watchdog that parks the block in ERROR.
module conv_sched #(
  parameter int PERIOD_W = 24,
  parameter int TIMEOUT  = 1000000,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                fs_conv,
  input  logic                fd_conv,
  output logic                fs_tran,
  input  logic                fd_tran,
  output logic                fs_send,
  input  logic                fd_send,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    overrun_cnt,
  output logic                timeout_err,
  output logic [1:0]          err_stage
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_REQ,
    S_CONV_REL,
    S_TRAN_REQ,
    S_TRAN_REL,
    S_SEND_REQ,
    S_SEND_REL,
    S_ERROR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PERIOD_W-1:0] r_timer;
  logic                r_en_d;
  logic [WD_W-1:0]     r_wdog;
  logic                r_fs_conv, r_fs_tran, r_fs_send, r_busy;
  logic [CNT_W-1:0]    r_frame_cnt, r_overrun_cnt;
  logic                r_timeout_err;
  logic [1:0]          r_err_stage;

  logic [PERIOD_W-1:0] w_term;
  logic                w_tick;
  logic [1:0]          w_stage_code;
  logic                w_fd_act;
  logic                w_in_hs;
  logic                w_frame_inc;

  // Period 0 and 1 share terminal value 0, i.e. a tick every enabled cycle.
  assign w_term = (period > PERIOD_W'(1)) ? period - PERIOD_W'(1) : '0;
  assign w_tick = enable & (~r_en_d | (r_timer >= w_term));

  // NOTE: state registers use non-blocking assignments and an asynchronous
  // active-low reset so every flop clears without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
      r_en_d  <= 1'b0;
    end else begin
      r_en_d <= enable;
      if (!enable || w_tick) r_timer <= '0;
      else                   r_timer <= r_timer + PERIOD_W'(1);
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_stage_code = 2'd0;
    w_fd_act     = 1'b0;
    case (r_state)
      S_CONV_REQ, S_CONV_REL: begin w_stage_code = 2'd1; w_fd_act = fd_conv; end
      S_TRAN_REQ, S_TRAN_REL: begin w_stage_code = 2'd2; w_fd_act = fd_tran; end
      S_SEND_REQ, S_SEND_REL: begin w_stage_code = 2'd3; w_fd_act = fd_send; end
      default: ;
    endcase
  end

  assign w_in_hs = (w_stage_code != 2'd0);

  always_comb begin
    w_next      = r_state;
    w_frame_inc = 1'b0;
    case (r_state)
      S_IDLE:     if (w_tick)    w_next = S_CONV_REQ;
      S_CONV_REQ: if (w_fd_act)  w_next = S_CONV_REL;
      S_CONV_REL: if (!w_fd_act) w_next = S_TRAN_REQ;
      S_TRAN_REQ: if (w_fd_act)  w_next = S_TRAN_REL;
      S_TRAN_REL: if (!w_fd_act) w_next = S_SEND_REQ;
      S_SEND_REQ: if (w_fd_act)  w_next = S_SEND_REL;
      S_SEND_REL: if (!w_fd_act) begin
        w_next      = S_IDLE;
        w_frame_inc = 1'b1;
      end
      S_ERROR:    if (!enable)   w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
    // The watchdog overrides any handshake progress in the same cycle.
    if (w_in_hs && (r_wdog == WD_LAST)) begin
      w_next      = S_ERROR;
      w_frame_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_wdog        <= '0;
      r_fs_conv     <= 1'b0;
      r_fs_tran     <= 1'b0;
      r_fs_send     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= '0;
      r_overrun_cnt <= '0;
      r_timeout_err <= 1'b0;
      r_err_stage   <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_fs_conv <= (w_next == S_CONV_REQ);
      r_fs_tran <= (w_next == S_TRAN_REQ);
      r_fs_send <= (w_next == S_SEND_REQ);
      r_busy    <= (w_next != S_IDLE);

      if ((w_next != r_state) || !w_in_hs) r_wdog <= '0;
      else                                 r_wdog <= r_wdog + WD_W'(1);

      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + CNT_W'(1);

      if (w_tick && (r_state != S_IDLE) && (r_overrun_cnt != {CNT_W{1'b1}}))
        r_overrun_cnt <= r_overrun_cnt + CNT_W'(1);

      if ((w_next == S_ERROR) && (r_state != S_ERROR)) begin
        r_timeout_err <= 1'b1;
        r_err_stage   <= w_stage_code;
      end else if ((r_state == S_ERROR) && (w_next == S_IDLE)) begin
        r_timeout_err <= 1'b0;
        r_err_stage   <= 2'd0;
      end
    end
  end

  assign fs_conv     = r_fs_conv;
  assign fs_tran     = r_fs_tran;
  assign fs_send     = r_fs_send;
  assign busy        = r_busy;
  assign frame_cnt   = r_frame_cnt;
  assign overrun_cnt = r_overrun_cnt;
  assign timeout_err = r_timeout_err;
  assign err_stage   = r_err_stage;

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: per-cycle comparison against a frame-level
// behavioural model, directed scenarios with hand-derived values, then random traffic.
module tb_conv_sched;

  localparam int PW   = 24;
  localparam int TO   = 64;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic          fs_conv, fs_tran, fs_send, busy, timeout_err;
  logic          fd_conv, fd_tran, fd_send;
  logic [1:0]    err_stage;
  logic [CW-1:0] frame_cnt, overrun_cnt;
  logic [3:1]    fdv = '0;

  int dly_a [1:3];
  int dly_r [1:3];
  int mode  [1:3];
  int a_cnt [1:3];
  int r_cnt [1:3];

  int total = 0;
  int bad   = 0;
  bit wrap_seen = 1'b0;
  int prev_fc = 0;

  assign fd_conv = fdv[1];
  assign fd_tran = fdv[2];
  assign fd_send = fdv[3];

  conv_sched #(.PERIOD_W(PW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period),
    .fs_conv(fs_conv), .fd_conv(fd_conv),
    .fs_tran(fs_tran), .fd_tran(fd_tran),
    .fs_send(fs_send), .fd_send(fd_send),
    .busy(busy), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err), .err_stage(err_stage)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic fs_of(input int s);
    case (s)
      1:       return fs_conv;
      2:       return fs_tran;
      default: return fs_send;
    endcase
  endfunction

  function automatic logic fd_of(input int s);
    case (s)
      1:       return fd_conv;
      2:       return fd_tran;
      default: return fd_send;
    endcase
  endfunction

  function automatic logic [22:0] dut_outs();
    return {fs_conv, fs_tran, fs_send, busy, timeout_err, err_stage, frame_cnt, overrun_cnt};
  endfunction

  // Responders: mode 0 answers after dly_a cycles of fs and releases dly_r cycles
  // after fs falls; mode 1 never answers; mode 2 holds done high.
  initial forever begin
    @(negedge clk);
    for (int s = 1; s <= 3; s++) begin
      if (mode[s] == 1) fdv[s] = 1'b0;
      else if (mode[s] == 2) fdv[s] = 1'b1;
      else if (fs_of(s)) begin
        r_cnt[s] = 0;
        a_cnt[s]++;
        if (a_cnt[s] >= dly_a[s]) fdv[s] = 1'b1;
      end else begin
        a_cnt[s] = 0;
        if (fdv[s]) begin
          r_cnt[s]++;
          if (r_cnt[s] >= dly_r[s]) begin
            fdv[s] = 1'b0;
            r_cnt[s] = 0;
          end
        end
      end
    end
  end

  // Behavioural model: stage 0 = idle, 1..3 = conv/tran/send, 4 = error;
  // m_rel says the stage has seen done and waits for it to drop.
  int m_stage = 0, m_rel = 0, m_wd = 0, m_timer = 0, m_en_d = 0;
  int m_frames = 0, m_over = 0, m_terr = 0, m_es = 0;

  task automatic model_step();
    int  term;
    bit  tick;
    logic fd_act;
    term = (period <= 1) ? 0 : int'(period) - 1;
    tick = enable && (m_en_d == 0 || m_timer >= term);
    m_timer = (!enable || tick) ? 0 : m_timer + 1;
    m_en_d = enable ? 1 : 0;
    if (tick && m_stage != 0 && m_over < CMAX) m_over++;
    if (m_stage >= 1 && m_stage <= 3) begin
      fd_act = fd_of(m_stage);
      if (m_wd == TO - 1) begin
        m_terr = 1; m_es = m_stage; m_stage = 4; m_rel = 0; m_wd = 0;
      end else if (m_rel == 0 && fd_act) begin
        m_rel = 1; m_wd = 0;
      end else if (m_rel == 1 && !fd_act) begin
        m_rel = 0; m_wd = 0;
        if (m_stage == 3) begin
          m_stage = 0;
          m_frames = (m_frames + 1) % (CMAX + 1);
        end else m_stage++;
      end else m_wd++;
    end else if (m_stage == 0) begin
      if (tick) begin m_stage = 1; m_rel = 0; m_wd = 0; end
    end else if (!enable) begin
      m_stage = 0; m_terr = 0; m_es = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_stage = 0; m_rel = 0; m_wd = 0; m_timer = 0; m_en_d = 0;
      m_frames = 0; m_over = 0; m_terr = 0; m_es = 0;
    end else model_step();
  end

  initial forever begin
    logic [22:0] e;
    @(negedge clk);
    if (rst) begin
      e = {m_stage == 1 && m_rel == 0, m_stage == 2 && m_rel == 0, m_stage == 3 && m_rel == 0,
           m_stage != 0, m_terr != 0, 2'(m_es), 8'(m_frames), 8'(m_over)};
      check("outputs", 32'(dut_outs()), 32'(e));
      check("fs_onehot", 32'($countones({fs_conv, fs_tran, fs_send}) <= 1), 32'd1);
      if (prev_fc == CMAX && frame_cnt == '0) wrap_seen = 1'b1;
      prev_fc = int'(frame_cnt);
    end
  end

  // Counts negedges until the given fs rises; limit+1 means it never did.
  task automatic wait_rise(input int s, input int limit, output int n);
    logic prv;
    prv = fs_of(s);
    n = 0;
    while (n <= limit) begin
      @(negedge clk);
      n++;
      if (fs_of(s) && !prv) return;
      prv = fs_of(s);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 400) begin @(negedge clk); k++; end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic set_delays(input int a, input int r, input int send_a);
    for (int s = 1; s <= 3; s++) begin dly_a[s] = a; dly_r[s] = r; mode[s] = 0; end
    dly_a[3] = send_a;
  endtask

  initial begin
    int n, k, f0, ov0, rises;
    set_delays(3, 2, 3);
    for (int s = 1; s <= 3; s++) begin a_cnt[s] = 0; r_cnt[s] = 0; end
    period = PW'(100);

    repeat (3) @(negedge clk);
    check("reset_state", 32'(dut_outs()), 32'd0);
    #2 rst = 1'b1;

    // Basic frame: first start one cycle after enable, next start 100 cycles later.
    repeat (6) @(negedge clk);
    enable = 1'b1;
    wait_rise(1, 20, n);
    check("first_start_latency", 32'(n), 32'd1);
    wait_rise(1, 300, n);
    check("start_gap_period100", 32'(n), 32'd100);
    check("frame_cnt_after_first", 32'(frame_cnt), 32'd1);
    check("no_overrun_basic", 32'(overrun_cnt), 32'd0);
    enable = 1'b0;
    wait_idle("idle_after_basic");

    // Overrun: 42-cycle frames on a 20-cycle period drop two ticks per frame.
    set_delays(3, 2, 30);
    period = PW'(20);
    f0 = int'(frame_cnt);
    ov0 = int'(overrun_cnt);
    @(negedge clk);
    enable = 1'b1;
    k = 0;
    while (int'(frame_cnt) != f0 + 3 && k < 600) begin @(negedge clk); k++; end
    check("three_frames_done", 32'(frame_cnt), 32'(f0 + 3));
    check("overrun_two_per_frame", 32'(int'(overrun_cnt) - ov0), 32'd6);
    enable = 1'b0;
    wait_idle("idle_after_overrun");

    // Back-to-back frames with period 0: saturation of overrun_cnt, wrap of frame_cnt.
    set_delays(1, 1, 1);
    period = PW'(0);
    @(negedge clk);
    enable = 1'b1;
    k = 0;
    while (!(wrap_seen && overrun_cnt == 8'(CMAX)) && k < 4000) begin @(negedge clk); k++; end
    check("frame_cnt_wrapped", 32'(wrap_seen), 32'd1);
    check("overrun_saturated", 32'(overrun_cnt), 32'(CMAX));
    repeat (20) @(negedge clk);
    check("overrun_holds", 32'(overrun_cnt), 32'(CMAX));
    enable = 1'b0;
    wait_idle("idle_after_wrap");

    // Timeout in TRAN_REQ: fs_tran stays up exactly TIMEOUT cycles.
    set_delays(2, 2, 2);
    mode[2] = 1;
    period = PW'(1000);
    @(negedge clk);
    enable = 1'b1;
    wait_rise(2, 100, n);
    check("tran_started", 32'(fs_tran), 32'd1);
    k = 0;
    while (fs_tran && k < 200) begin k++; @(negedge clk); end
    check("tran_req_length", 32'(k), 32'(TO));
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    check("err_stage_tran", 32'(err_stage), 32'd2);
    check("busy_in_error", 32'(busy), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("error_exit", 32'({busy, timeout_err, err_stage}), 32'd0);
    mode[2] = 0;

    // Stuck-high conversion done: one-cycle REQ, then timeout in CONV_REL.
    mode[1] = 2;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_rise(1, 10, n);
    k = 0;
    while (fs_conv && k < 50) begin k++; @(negedge clk); end
    check("stuck_req_one_cycle", 32'(k), 32'd1);
    k = 0;
    while (!timeout_err && k < 200) begin @(negedge clk); k++; end
    check("stuck_timeout", 32'(timeout_err), 32'd1);
    check("err_stage_conv", 32'(err_stage), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    mode[1] = 0;
    repeat (5) @(negedge clk);

    // Enable dropped mid-frame: the frame finishes, then nothing restarts.
    set_delays(3, 2, 3);
    period = PW'(30);
    enable = 1'b1;
    k = 0;
    while (!fs_tran && k < 100) begin @(negedge clk); k++; end
    f0 = int'(frame_cnt);
    enable = 1'b0;
    wait_idle("idle_after_stop");
    check("stop_frame_completed", 32'(frame_cnt), 32'((f0 + 1) % (CMAX + 1)));
    rises = 0;
    for (int c = 0; c < 150; c++) begin
      logic p;
      p = fs_conv;
      @(negedge clk);
      if (fs_conv && !p) rises++;
    end
    check("no_restart_5_periods", 32'(rises), 32'd0);

    // Asynchronous reset during SEND_REQ clears outputs with no clock edge.
    enable = 1'b1;
    k = 0;
    while (!fs_send && k < 100) begin @(negedge clk); k++; end
    check("send_reached", 32'(fs_send), 32'd1);
    #2 rst = 1'b0;
    #1 check("async_reset_clears", 32'(dut_outs()), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) period = PW'($urandom_range(0, 25));
      if ($urandom_range(0, 49) == 0)
        for (int s = 1; s <= 3; s++) begin
          dly_a[s] = $urandom_range(1, 6);
          dly_r[s] = $urandom_range(1, 6);
        end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
